srl_error_uart_reporter: RTL and testbench

//   Sits directly downstream of the SRL chain testers in the xc7 SRL hardware tests.

---
 rtl/srl_report_pkg.sv | 20 ++
 rtl/srl_error_uart_reporter_if.sv | 15 +
 rtl/uart_tx_8n1.sv | 91 +++++++++
 rtl/srl_error_uart_reporter.sv | 88 ++++++++
 tb/tb_srl_error_uart_reporter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/srl_report_pkg.sv
// rtl/srl_report_pkg.sv - ASCII constants, hex helper and UART state enum for the SRL error reporter
package srl_report_pkg;

  localparam logic [7:0] ASCII_OK  = 8'h4B;
  localparam logic [7:0] ASCII_ERR = 8'h45;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/srl_error_uart_reporter_if.sv
// rtl/srl_error_uart_reporter_if.sv - error inputs, sticky latch, busy and UART tx of the reporter
interface srl_error_uart_reporter_if #(
  parameter int NUM_CH = 8
);

  logic [NUM_CH-1:0] error;
  logic              clr;
  logic [NUM_CH-1:0] error_lat;
  logic              busy;
  logic              tx;

  modport master (output error, output clr, input error_lat, input busy, input tx);
  modport slave  (input error, input clr, output error_lat, output busy, output tx);

endinterface

// File: rtl/uart_tx_8n1.sv
// rtl/uart_tx_8n1.sv - 8N1 UART transmitter with valid/ready byte input, back-to-back capable
module uart_tx_8n1
  import srl_report_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_tdata_i,
  input  logic       s_tvalid_i,
  output logic       s_tready_o,
  output logic       tx_o
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  tx_state_e        state_q;
  logic [DIVW-1:0]  div_q;
  logic [2:0]       bit_q;
  logic [7:0]       sh_q;
  logic             tx_q;
  logic             div_last;

  assign div_last   = (div_q == DIVW'(CLK_DIV - 1));
  // Accepting in the last stop cycle keeps consecutive bytes gap-free.
  assign s_tready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && div_last);
  assign tx_o       = tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s_tvalid_i) begin
            sh_q    <= s_tdata_i;
            div_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (div_last) begin
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= sh_q[0];
            sh_q    <= sh_q >> 1;
            state_q <= ST_DATA;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (div_last) begin
            div_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= sh_q[0];
              sh_q  <= sh_q >> 1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (div_last) begin
            if (s_tvalid_i) begin
              sh_q    <= s_tdata_i;
              div_q   <= '0;
              tx_q    <= 1'b0;
              state_q <= ST_START;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/srl_error_uart_reporter.sv
// rtl/srl_error_uart_reporter.sv - sticky SRL error latch with periodic ASCII status frames over UART
// Optional SRL_REPORT_EVENT_TRIG_EN: also trigger a report whenever the latch gains a new bit.
module srl_error_uart_reporter
  import srl_report_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int CLK_DIV       = 868,
  parameter int REPORT_PERIOD = 50_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  srl_error_uart_reporter_if.slave  rpt_if
);

  localparam int NHEX   = NUM_CH / 4;
  localparam int NBYTES = NHEX + 3;
  localparam int IDXW   = $clog2(NBYTES + 1);
  localparam int CNTW   = $clog2(REPORT_PERIOD);

  logic [NUM_CH-1:0] lat_q, lat_d, snap_q;
  logic [CNTW-1:0]   cnt_q;
  logic [IDXW-1:0]   idx_q;
  logic              pending_q, busy_q;
  logic              tick, gain, take;
  logic              tx_valid, tx_ready;
  logic [7:0]        byte_sel;
  logic [3:0]        nib;

  assign lat_d    = (rpt_if.clr ? '0 : lat_q) | rpt_if.error;
  assign tick     = (cnt_q == CNTW'(REPORT_PERIOD - 1));
  assign take     = !busy_q && pending_q;
  assign tx_valid = busy_q && (idx_q != IDXW'(NBYTES));

`ifdef SRL_REPORT_EVENT_TRIG_EN
  assign gain = |(lat_d & ~lat_q);
`else
  assign gain = 1'b0;
`endif

  // Byte 0 is the OK/ERR marker, then hex digits MS nibble first, then CR LF.
  always_comb begin
    nib = '0;
    for (int k = 0; k < NHEX; k++) begin
      if (idx_q == IDXW'(NHEX - k)) nib = snap_q[4*k +: 4];
    end
    byte_sel = ASCII_LF;
    if (idx_q == '0)                   byte_sel = (snap_q == '0) ? ASCII_OK : ASCII_ERR;
    else if (idx_q <= IDXW'(NHEX))     byte_sel = hex_ascii(nib);
    else if (idx_q == IDXW'(NHEX + 1)) byte_sel = ASCII_CR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_q     <= '0;
      snap_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      lat_q     <= lat_d;
      cnt_q     <= tick ? '0 : cnt_q + 1'b1;
      pending_q <= (pending_q && !take) || tick || gain;
      if (take) begin
        busy_q <= 1'b1;
        idx_q  <= '0;
        snap_q <= lat_q;
      end else if (busy_q && tx_ready) begin
        // The ready in the final stop cycle with nothing left ends the frame.
        if (tx_valid) idx_q  <= idx_q + 1'b1;
        else          busy_q <= 1'b0;
      end
    end
  end

  uart_tx_8n1 #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk        (clk),
    .rst        (rst),
    .s_tdata_i  (byte_sel),
    .s_tvalid_i (tx_valid),
    .s_tready_o (tx_ready),
    .tx_o       (rpt_if.tx)
  );

  assign rpt_if.error_lat = lat_q;
  assign rpt_if.busy      = busy_q;

endmodule

// File: tb/tb_srl_error_uart_reporter.sv
// tb/tb_srl_error_uart_reporter.sv - directed vector bench for srl_error_uart_reporter
module tb_srl_error_uart_reporter;

  localparam int NUM_CH = 8;
  localparam int CLK_DIV = 4;
  localparam int RP = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rel_cyc = 0;
  int   start_cyc = 0;

  typedef struct {
    logic [7:0] err;
    logic       clr;
    logic [7:0] exp_lat;
  } vec_t;
  vec_t vecs [10];

  srl_error_uart_reporter_if #(.NUM_CH(NUM_CH)) rif();

  srl_error_uart_reporter #(
    .NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .REPORT_PERIOD(RP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rpt_if (rif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input int limit, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < limit) begin
      @(negedge clk);
      n++;
      if (rif.tx === 1'b0) begin
        ok = 1'b1;
        start_cyc = cyc;
      end
    end
  endtask

  // Called on the first low sample of a start bit; returns on the mid stop-bit sample.
  task automatic recv_byte(output logic [7:0] b);
    repeat (6) @(negedge clk);
    b[0] = rif.tx;
    for (int i = 1; i < 8; i++) begin
      repeat (CLK_DIV) @(negedge clk);
      b[i] = rif.tx;
    end
    repeat (CLK_DIV) @(negedge clk);
    check("stop_bit", {31'b0, rif.tx}, 32'd1);
  endtask

  task automatic recv_frame(input string name, input logic [39:0] exp, input int exp_start,
                            input int limit, input bit clr_mid);
    bit ok;
    int prev;
    logic [7:0] got;
    prev = 0;
    for (int b = 0; b < 5; b++) begin
      wait_start((b == 0) ? limit : 3, ok);
      check({name, " start_seen"}, {31'b0, ok}, 32'd1);
      if (!ok) return;
      if (b == 0) check({name, " start_cycle"}, start_cyc - rel_cyc, exp_start);
      else        check({name, " byte_gap"}, start_cyc - prev, 32'd40);
      prev = start_cyc;
      recv_byte(got);
      check($sformatf("%s byte%0d", name, b), {24'h0, got}, {24'h0, exp[39-8*b -: 8]});
      if (b == 0) check({name, " busy"}, {31'b0, rif.busy}, 32'd1);
      if (clr_mid && b == 1) begin
        rif.clr = 1'b1;
        @(negedge clk);
        rif.clr = 1'b0;
        check({name, " lat_after_clr"}, {24'h0, rif.error_lat}, 32'h0);
      end
    end
  endtask

  task automatic busy_tail(input string name);
    @(negedge clk);
    check({name, " busy_last_stop"}, {31'b0, rif.busy}, 32'd1);
    @(negedge clk);
    check({name, " busy_idle"}, {31'b0, rif.busy}, 32'd0);
  endtask

  initial begin
    bit ok;
    logic [7:0] got;

    vecs[0] = '{8'h00, 1'b1, 8'h00};
    vecs[1] = '{8'hA0, 1'b0, 8'hA0};
    vecs[2] = '{8'h05, 1'b0, 8'hA5};
    vecs[3] = '{8'h00, 1'b0, 8'hA5};
    vecs[4] = '{8'h01, 1'b1, 8'h01};
    vecs[5] = '{8'h00, 1'b0, 8'h01};
    vecs[6] = '{8'h40, 1'b1, 8'h40};
    vecs[7] = '{8'h00, 1'b1, 8'h00};
    vecs[8] = '{8'hA5, 1'b0, 8'hA5};
    vecs[9] = '{8'h00, 1'b0, 8'hA5};

    rif.error = '0;
    rif.clr = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset tx", {31'b0, rif.tx}, 32'd1);
    check("reset busy", {31'b0, rif.busy}, 32'd0);
    check("reset lat", {24'h0, rif.error_lat}, 32'h0);
    rst = 1'b0;
    rel_cyc = cyc;

`ifdef SRL_REPORT_EVENT_TRIG_EN
    repeat (20) @(negedge clk);
    rif.error = 8'h80;
    recv_frame("evt", 40'h4538300D0A, 23, 3, 1'b0);
    rif.error = 8'h00;
    @(negedge clk);
    check("evt lat", {24'h0, rif.error_lat}, 32'h80);
`else
    recv_frame("f1", 40'h4B30300D0A, 402, 410, 1'b0);
    busy_tail("f1");

    @(negedge clk);
    rif.error = 8'h08;
    @(negedge clk);
    rif.error = 8'h00;
    check("pulse3 lat", {24'h0, rif.error_lat}, 32'h08);
    recv_frame("f2", 40'h4530380D0A, 802, 900, 1'b0);
    busy_tail("f2");

    for (int i = 0; i < 10; i++) begin
      rif.error = vecs[i].err;
      rif.clr = vecs[i].clr;
      @(negedge clk);
      check($sformatf("latch vec%0d", i), {24'h0, rif.error_lat}, {24'h0, vecs[i].exp_lat});
    end
    rif.error = 8'h00;
    rif.clr = 1'b0;

    recv_frame("f3", 40'h4541350D0A, 1202, 900, 1'b1);
    busy_tail("f3");
    check("f3 lat_after", {24'h0, rif.error_lat}, 32'h0);

    wait_start(900, ok);
    check("f4 start_seen", {31'b0, ok}, 32'd1);
    check("f4 start_cycle", start_cyc - rel_cyc, 32'd1602);
    recv_byte(got);
    check("f4 byte0", {24'h0, got}, 32'h4B);
    rif.error = 8'h3C;
    @(negedge clk);
    rif.error = 8'h00;
    check("f4 lat", {24'h0, rif.error_lat}, 32'h3C);
    wait_start(3, ok);
    check("f4 byte1 start", {31'b0, ok}, 32'd1);
    repeat (6) @(negedge clk);
    check("f4 data bit0 low", {31'b0, rif.tx}, 32'd0);
    rst = 1'b1;
    #1;
    check("midrst tx", {31'b0, rif.tx}, 32'd1);
    check("midrst busy", {31'b0, rif.busy}, 32'd0);
    check("midrst lat", {24'h0, rif.error_lat}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel_cyc = cyc;

    recv_frame("f5", 40'h4B30300D0A, 402, 410, 1'b0);
    busy_tail("f5");

    @(negedge clk);
    rif.error = 8'h80;
    @(negedge clk);
    rif.error = 8'h00;
    check("err7 lat", {24'h0, rif.error_lat}, 32'h80);
    recv_frame("f6", 40'h4538300D0A, 802, 900, 1'b0);
    busy_tail("f6");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
